// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and constants for the FIFO drain controller
package fifo_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int SKID_DEPTH     = 2;
  localparam int OCC_WIDTH      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_drain_skid.sv
// rtl/fifo_drain_skid.sv - 2-entry in-order skid queue absorbing the FIFO read latency
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_WIDTH-1:0]  occ
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [OCC_WIDTH-1:0]  r_occ;
  logic                  w_pop;

  assign w_pop     = pop && (r_occ != '0);
  assign head_data = r_head;
  assign occ       = r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          if (r_occ == '0) r_head <= push_data;
          else             r_tail <= push_data;
          r_occ <= r_occ + OCC_WIDTH'(1);
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - OCC_WIDTH'(1);
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever survives the pop
          if (r_occ == OCC_WIDTH'(1)) begin
            r_head <= push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - FIFO read-side drain controller with skid buffer, counter and sticky underflow
// Optional burst start (half-full or idle timeout) enabled by FIFO_DRAIN_BURST_EN.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_enb,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_half,
  input  logic                  fifo_underflow,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  drain_count,
  output logic                  err_underflow
);

  drain_state_e          r_state;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_err;
  logic [OCC_WIDTH-1:0]  w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_pop;
  logic                  w_has_room;
  logic                  w_start;
  logic [2:0]            w_committed;

  fifo_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (r_inflight),
    .push_data(fifo_rd_data),
    .pop      (w_pop),
    .head_data(w_head),
    .occ      (w_occ)
  );

  assign out_valid     = (w_occ != '0);
  assign out_data      = w_head;
  assign w_pop         = out_valid && out_ready;
  assign drain_count   = r_count;
  assign err_underflow = r_err;

  // Words held plus the one in flight must leave room once this cycle's pop is counted
  assign w_committed = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_has_room  = w_committed < (3'd2 + {2'b00, w_pop});
  assign fifo_rd_enb = !rst && (r_state == DRAIN) && !fifo_empty && w_has_room;

`ifdef FIFO_DRAIN_BURST_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] r_timer;

  assign w_start = fifo_half || (!fifo_empty && (r_timer == TW'(TIMEOUT - 1)));

  always_ff @(posedge clk) begin
    if (rst || fifo_empty || (r_state == DRAIN)) begin
      r_timer <= '0;
    end else if (r_timer != TW'(TIMEOUT - 1)) begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  logic w_unused;
  assign w_unused = fifo_half ^ TIMEOUT[0];
  assign w_start  = !fifo_empty;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_enb;
      if (w_pop) r_count <= r_count + CNT_WIDTH'(1);
      if (fifo_underflow) r_err <= 1'b1;
      case (r_state)
        IDLE:    if (w_start) r_state <= DRAIN;
        DRAIN:   if (fifo_empty && !r_inflight) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - self-checking bench for fifo_drain_ctrl with a queue-based FIFO and scoreboard
module tb_fifo_drain_ctrl;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_enb;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_half = 1'b0;
  logic          fifo_underflow = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] drain_count;
  logic          err_underflow;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] obs[$];
  int            pop_cyc[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rd_count = 0;
  int            delivered = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fifo_rd_enb(fifo_rd_enb), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_half(fifo_half), .fifo_underflow(fifo_underflow),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drain_count(drain_count), .err_underflow(err_underflow)
  );

  // Behavioural FIFO: rd_data valid the cycle after rd_enb is sampled
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_enb && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
    fifo_half  <= (fq.size() >= 8);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        obs.push_back(out_data);
        pop_cyc.push_back(cyc);
      end
      if (fifo_rd_enb) rd_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; wr_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    checks++; if (drain_count !== '0) begin errors++; $display("FAIL reset_drain_count got %0d want 0", drain_count); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err_underflow got %0b want 0", err_underflow); end
    checks++; if (fifo_rd_enb !== 1'b0) begin errors++; $display("FAIL reset_rd_enb got %0b want 0", fifo_rd_enb); end
    tick();
    rst = 1'b0;
    delivered = 0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp[$];
    int t_fall = -1;
    int t_valid = -1;
    exp = '{8'h11, 8'h22, 8'h33};
    obs.delete(); pop_cyc.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      wr_en = (c < 3);
      if (c < 3) wr_data = exp[c];
      @(negedge clk);
      if (t_fall < 0 && !fifo_empty) t_fall = cyc;
      if (t_valid < 0 && out_valid) t_valid = cyc;
      tick();
    end
    wr_en = 1'b0;
    delivered += 3;
    checks++; if (t_valid - t_fall !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", t_valid - t_fall); end
    checks++; if (obs.size() !== 3) begin errors++; $display("FAIL basic_count_words got %0d want 3", obs.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== exp[i]) begin
        errors++; $display("FAIL basic_word%0d got %0h want %0h", i, (i < obs.size()) ? obs[i] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (pop_cyc.size() != 3 || pop_cyc[2] - pop_cyc[0] != 2) begin
      errors++; $display("FAIL basic_back_to_back got %0d pops want 3 consecutive", pop_cyc.size());
    end
    checks++; if (drain_count !== CW'(delivered)) begin errors++; $display("FAIL basic_drain_count got %0d want %0d", drain_count, CW'(delivered)); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp[$];
    int base_rd = rd_count;
    obs.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp.push_back(DW'($urandom));
    for (int c = 0; c < 15; c++) begin
      wr_en = (c < 5);
      if (c < 5) wr_data = exp[c];
      @(negedge clk);
      if (out_valid) begin
        checks++; if (out_data !== exp[0]) begin errors++; $display("FAIL stall_hold got %0h want %0h", out_data, exp[0]); end
      end
      tick();
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (rd_count - base_rd !== 2) begin errors++; $display("FAIL stall_reads got %0d want 2", rd_count - base_rd); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %0b want 1", out_valid); end
    tick();
    out_ready = 1'b1;
    repeat (15) tick();
    delivered += 5;
    checks++; if (obs.size() !== 5) begin errors++; $display("FAIL stall_release_count got %0d want 5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp[i]) begin errors++; $display("FAIL stall_release_word%0d got %0h want %0h", i, obs[i], exp[i]); end
    end
    checks++; if (drain_count !== CW'(delivered)) begin errors++; $display("FAIL stall_drain_count got %0d want %0d", drain_count, CW'(delivered)); end
  endtask

  task automatic test_random_wrap();
    logic [DW-1:0] exp[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            n = 0;
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    delivered = 0;
    obs.delete();
    for (int c = 0; c < 120; c++) begin
      if (n < 17 && (c >= 40 || $urandom_range(0, 2) != 0)) begin
        wr_en = 1'b1; wr_data = DW'($urandom); exp.push_back(wr_data); n++;
      end else begin
        wr_en = 1'b0;
      end
      out_ready = (c >= 80) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL rand_hold got v=%0b d=%0h want v=1 d=%0h", out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
    end
    wr_en = 1'b0;
    delivered += exp.size();
    checks++; if (obs.size() !== exp.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp[i]) begin errors++; $display("FAIL rand_word%0d got %0h want %0h", i, obs[i], exp[i]); end
    end
    checks++; if (drain_count !== CW'(delivered)) begin errors++; $display("FAIL wrap_drain_count got %0d want %0d", drain_count, CW'(delivered)); end
  endtask

  task automatic test_rst_midflight();
    logic [DW-1:0] w1, w2;
    logic          found = 1'b0;
    w1 = DW'($urandom); w2 = w1 + 8'h5A;
    obs.delete();
    out_ready = 1'b1;
    wr_en = 1'b1; wr_data = w1; tick();
    wr_data = w2; tick();
    wr_en = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (fifo_rd_enb) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_read_timeout got none want read"); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (fifo_rd_enb !== 1'b0) begin errors++; $display("FAIL midrst_rd_forced got %0b want 0", fifo_rd_enb); end
    tick();
    rst = 1'b0;
    delivered = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
    checks++; if (drain_count !== '0) begin errors++; $display("FAIL midrst_count got %0d want 0", drain_count); end
    repeat (10) tick();
    delivered += 1;
    checks++;
    if (obs.size() != 1 || obs[0] !== w2) begin
      errors++; $display("FAIL midrst_discard got %0d words first %0h want 1 word %0h", obs.size(), (obs.size() > 0) ? obs[0] : 8'hxx, w2);
    end
  endtask

  task automatic test_underflow();
    fifo_underflow = 1'b1; tick(); fifo_underflow = 1'b0;
    @(negedge clk);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got %0b want 1", err_underflow); end
    repeat (5) tick();
    @(negedge clk);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %0b want 1", err_underflow); end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    delivered = 0;
    @(negedge clk);
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got %0b want 0", err_underflow); end
    tick();
  endtask

`ifdef FIFO_DRAIN_BURST_EN
  task automatic test_burst();
    int t_fall = -1, t_rd = -1, t_half = -1;
    logic prev_half = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      wr_en = (c < 3); wr_data = DW'(c);
      @(negedge clk);
      if (t_fall < 0 && !fifo_empty) t_fall = cyc;
      if (t_rd < 0 && fifo_rd_enb) t_rd = cyc;
      tick();
    end
    checks++; if (t_rd - t_fall !== TO) begin errors++; $display("FAIL burst_timeout got %0d want %0d", t_rd - t_fall, TO); end
    t_rd = -1;
    for (int c = 0; c < 40; c++) begin
      wr_en = (c < 8); wr_data = DW'(c);
      @(negedge clk);
      if (t_half < 0 && fifo_half && !prev_half) t_half = cyc;
      if (t_rd < 0 && fifo_rd_enb) t_rd = cyc;
      prev_half = fifo_half;
      tick();
    end
    wr_en = 1'b0;
    checks++; if (t_rd - t_half !== 1) begin errors++; $display("FAIL burst_half got %0d want 1", t_rd - t_half); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FIFO_DRAIN_BURST_EN
    test_underflow();
    test_burst();
`else
    test_basic();
    test_backpressure();
    test_random_wrap();
    test_rst_midflight();
    test_underflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
